// File: rtl/polar_enc_pkg.sv
// Shared types and helpers for the polar encoder front-end frame controller.
package polar_enc_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        LAUNCH,
        WAIT,
        DRAIN
    } state_t;

    localparam int unsigned N_DEFAULT = 256;

    // Ceiling log2, floored at 1 so single-beat counters still get one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/polar_frame_serdes.sv
// Width-generic packer (PACK=1: narrow beats into a wide word) or unpacker
// (PACK=0: wide word parallel-loaded, read out one narrow slice per beat).
module polar_frame_serdes
    import polar_enc_pkg::*;
#(
    parameter int unsigned WIDE_W   = N_DEFAULT,
    parameter int unsigned NARROW_W = 32,
    parameter bit          PACK     = 1'b1,
    parameter int unsigned BEATS    = WIDE_W / NARROW_W,
    parameter int unsigned CW       = clog2(BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic                load,
    input  logic [NARROW_W-1:0] narrow_in,
    input  logic [WIDE_W-1:0]   wide_in,
    output logic [WIDE_W-1:0]   wide_out,
    output logic [NARROW_W-1:0] narrow_out,
    output logic [CW-1:0]       cnt,
    output logic                last
);

    localparam int unsigned BW = clog2(WIDE_W);

    logic [BW-1:0] base;

    assign base       = BW'(cnt) * BW'(NARROW_W);
    assign last       = (cnt == CW'(BEATS - 1));
    assign narrow_out = wide_out[base +: NARROW_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wide_out <= '0;
            cnt      <= '0;
        end else begin
            if (load) begin
                wide_out <= wide_in;
            end else if (step && PACK) begin
                wide_out[base +: NARROW_W] <= narrow_in;
            end
            if (step) begin
                cnt <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/polar_enc_frame_ctrl.sv
// Polar encoder frame sequencer: packs input beats, masks frozen bits, launches
// the datapath, captures its result under a watchdog and streams it out.
module polar_enc_frame_ctrl
    import polar_enc_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TMO   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [N-1:0]     cfg_frozen,
    input  logic             err_clr,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [IN_W-1:0]  s_data,
    output logic             dp_vld_i,
    output logic [N-1:0]     dp_din,
    input  logic             dp_vld_o,
    input  logic [N-1:0]     dp_dout,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             err_tmo
);

    localparam int unsigned IBEATS = N / IN_W;
    localparam int unsigned OBEATS = N / OUT_W;
    localparam int unsigned ICW    = clog2(IBEATS);
    localparam int unsigned OCW    = clog2(OBEATS);
    localparam int unsigned TW     = clog2(TMO + 1);

    state_t          state;
    logic [N-1:0]    frozen;
    logic [N-1:0]    ibuf;
    logic [ICW-1:0]  icnt;
    logic [TW-1:0]   timer;
    logic            in_hs;
    logic            in_last;
    logic            out_hs;
    logic            out_last;
    logic            capture;
    logic            timeout;
    logic [IN_W-1:0] unused_islice;
    logic [N-1:0]    unused_obuf;
    logic [OCW-1:0]  unused_ocnt;

    assign s_rdy   = (state == COLLECT);
    assign in_hs   = s_vld && s_rdy;
    assign out_hs  = m_vld && m_rdy;
    assign capture = (state == WAIT) && dp_vld_o;
    // A result arriving on the final allowed cycle still beats the watchdog.
    assign timeout = (state == WAIT) && !dp_vld_o && (timer == TW'(TMO - 1));
    assign busy    = (state != COLLECT) || (icnt != '0);
    assign m_last  = m_vld && out_last;

    polar_frame_serdes #(
        .WIDE_W   (N),
        .NARROW_W (IN_W),
        .PACK     (1'b1)
    ) u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (in_hs),
        .load       (1'b0),
        .narrow_in  (s_data),
        .wide_in    ('0),
        .wide_out   (ibuf),
        .narrow_out (unused_islice),
        .cnt        (icnt),
        .last       (in_last)
    );

    polar_frame_serdes #(
        .WIDE_W   (N),
        .NARROW_W (OUT_W),
        .PACK     (1'b0)
    ) u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (out_hs),
        .load       (capture),
        .narrow_in  ('0),
        .wide_in    (dp_dout),
        .wide_out   (unused_obuf),
        .narrow_out (m_data),
        .cnt        (unused_ocnt),
        .last       (out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            frozen   <= '0;
            dp_din   <= '0;
            dp_vld_i <= 1'b0;
            timer    <= '0;
            m_vld    <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            dp_vld_i <= 1'b0;

            // Mask may only change between frames so a frame never sees two masks.
            if (cfg_we && (state == COLLECT) && (icnt == '0)) begin
                frozen <= cfg_frozen;
            end

            if (timeout) begin
                err_tmo <= 1'b1;
            end else if (err_clr) begin
                err_tmo <= 1'b0;
            end

            case (state)
                COLLECT: begin
                    if (in_hs && in_last) state <= LAUNCH;
                end
                LAUNCH: begin
                    dp_din   <= ibuf & ~frozen;
                    dp_vld_i <= 1'b1;
                    timer    <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (dp_vld_o) begin
                        m_vld <= 1'b1;
                        state <= DRAIN;
                    end else if (timeout) begin
                        state <= COLLECT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_hs && out_last) begin
                        m_vld <= 1'b0;
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_enc_frame_ctrl.sv
// Directed bench for polar_enc_frame_ctrl with a 1-cycle bit-reversing datapath model.
module tb_polar_enc_frame_ctrl;

    localparam int unsigned N     = 256;
    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned TMO   = 15;

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] data;
        logic [N-1:0] exp_din;
        logic [3:0]   pat;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [N-1:0]     cfg_frozen = '0;
    logic             err_clr = 1'b0;
    logic             s_vld = 1'b0;
    logic             s_rdy;
    logic [IN_W-1:0]  s_data = '0;
    logic             dp_vld_i;
    logic [N-1:0]     dp_din;
    logic             dp_vld_o;
    logic [N-1:0]     dp_dout;
    logic             m_vld;
    logic             m_rdy = 1'b0;
    logic [OUT_W-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             err_tmo;

    logic             model_vld = 1'b0;
    logic             force_vld = 1'b0;
    logic             dp_en = 1'b1;
    logic [N-1:0]     model_dout = '0;

    int tests = 0;
    int failed = 0;
    vec_t vecs [4];

    polar_enc_frame_ctrl #(
        .N     (N),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_frozen (cfg_frozen),
        .err_clr    (err_clr),
        .s_vld      (s_vld),
        .s_rdy      (s_rdy),
        .s_data     (s_data),
        .dp_vld_i   (dp_vld_i),
        .dp_din     (dp_din),
        .dp_vld_o   (dp_vld_o),
        .dp_dout    (dp_dout),
        .m_vld      (m_vld),
        .m_rdy      (m_rdy),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    always @(posedge clk) begin
        model_vld  <= dp_en & dp_vld_i;
        model_dout <= bitrev(dp_din);
    end

    assign dp_vld_o = model_vld | force_vld;
    assign dp_dout  = model_dout;

    task automatic check_bit(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(s_rdy && !busy) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_bit("idle_reached", s_rdy && !busy, 1'b1);
    endtask

    task automatic load_mask(input logic [N-1:0] mask);
        cfg_frozen = mask;
        cfg_we     = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
    endtask

    task automatic send_beats(input logic [N-1:0] data, input int first, input int stop);
        for (int b = first; b < stop; b++) begin
            check_bit("s_rdy_collect", s_rdy, 1'b1);
            s_vld  = 1'b1;
            s_data = data[8'(b * IN_W) +: IN_W];
            @(negedge clk);
        end
        s_vld = 1'b0;
    endtask

    // Called at the negedge right after the last input handshake edge.
    task automatic launch_and_drain(input logic [N-1:0] exp_din, input logic [3:0] pat,
                                    input int rst_beat);
        logic [N-1:0] exp_out;
        int beat;
        int k;
        check_bit("launch_s_rdy_low", s_rdy, 1'b0);
        check_bit("launch_no_pulse_yet", dp_vld_i, 1'b0);
        check_bit("launch_busy", busy, 1'b1);
        @(negedge clk);
        check_bit("dp_vld_i_pulse", dp_vld_i, 1'b1);
        check_vec("dp_din", dp_din, exp_din);
        @(negedge clk);
        check_bit("dp_vld_i_single", dp_vld_i, 1'b0);
        check_bit("m_vld_not_early", m_vld, 1'b0);
        @(negedge clk);
        exp_out = bitrev(exp_din);
        beat = 0;
        k = 0;
        while (beat < 8 && k < 64) begin
            if (beat == rst_beat) begin
                m_rdy = 1'b0;
                rst_n = 1'b0;
                #1;
                check_bit("rst_m_vld", m_vld, 1'b0);
                check_bit("rst_busy", busy, 1'b0);
                check_bit("rst_err_tmo", err_tmo, 1'b0);
                check_vec("rst_dp_din", dp_din, '0);
                check_bit("rst_dp_vld_i", dp_vld_i, 1'b0);
                check_bit("rst_m_last", m_last, 1'b0);
                check_bit("rst_s_rdy", s_rdy, 1'b1);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            m_rdy = pat[k[1:0]];
            check_bit("drain_m_vld", m_vld, 1'b1);
            check_bit("drain_s_rdy_low", s_rdy, 1'b0);
            check_vec("m_data", {224'd0, m_data}, {224'd0, exp_out[8'(beat * OUT_W) +: OUT_W]});
            check_bit("m_last", m_last, beat == 7);
            if (m_rdy) beat++;
            k++;
            @(negedge clk);
        end
        m_rdy = 1'b0;
        check_bit("drain_all_beats", beat == 8, 1'b1);
        check_bit("post_m_vld_low", m_vld, 1'b0);
        check_bit("post_busy_low", busy, 1'b0);
        check_bit("post_s_rdy", s_rdy, 1'b1);
    endtask

    task automatic timeout_frame(input logic [N-1:0] data, input logic hold_clr);
        dp_en   = 1'b0;
        err_clr = hold_clr;
        send_beats(data, 0, 8);
        repeat (TMO) @(negedge clk);
        check_bit("tmo_not_yet", err_tmo, 1'b0);
        check_bit("tmo_busy_waiting", busy, 1'b1);
        @(negedge clk);
        err_clr = 1'b0;
        check_bit("tmo_set", err_tmo, 1'b1);
        check_bit("tmo_back_collect", s_rdy, 1'b1);
        check_bit("tmo_not_busy", busy, 1'b0);
        check_bit("tmo_no_output", m_vld, 1'b0);
        dp_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{mask: '0,
                    data: 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                    exp_din: 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
                    pat: 4'b1111};
        vecs[1] = '{mask: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000000_00000000_00000000,
                    data: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                    exp_din: 256'h00000000_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                    pat: 4'b1111};
        vecs[2] = '{mask: 256'hFFFF0000_00000000_00000000_00000000_00000000_00000000_00000000_0000FFFF,
                    data: 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_13579BDF_2468ACE0_0F0F0F0F_A5A5A5A5,
                    exp_din: 256'h0000BEEF_01234567_89ABCDEF_CAFEF00D_13579BDF_2468ACE0_0F0F0F0F_A5A50000,
                    pat: 4'b1001};
        vecs[3] = '{mask: '0,
                    data: 256'h80000000_40000000_20000000_10000000_08000000_04000000_02000000_01000000,
                    exp_din: 256'h80000000_40000000_20000000_10000000_08000000_04000000_02000000_01000000,
                    pat: 4'b1111};

        // Reset values
        @(negedge clk);
        check_bit("reset_s_rdy", s_rdy, 1'b1);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_m_vld", m_vld, 1'b0);
        check_bit("reset_m_last", m_last, 1'b0);
        check_bit("reset_dp_vld_i", dp_vld_i, 1'b0);
        check_vec("reset_dp_din", dp_din, '0);
        check_bit("reset_err_tmo", err_tmo, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: plain frame, frozen upper half, backpressured drain
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            load_mask(vecs[i].mask);
            send_beats(vecs[i].data, 0, 8);
            launch_and_drain(vecs[i].exp_din, vecs[i].pat, 8);
        end

        // Late cfg_we and stray dp_vld_o during COLLECT are ignored
        wait_idle();
        load_mask('0);
        send_beats(vecs[2].data, 0, 4);
        cfg_frozen = '1;
        cfg_we     = 1'b1;
        force_vld  = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
        force_vld  = 1'b0;
        cfg_frozen = '0;
        check_bit("ignored_busy", busy, 1'b1);
        check_bit("ignored_s_rdy", s_rdy, 1'b1);
        check_bit("ignored_m_vld", m_vld, 1'b0);
        send_beats(vecs[2].data, 4, 8);
        launch_and_drain(vecs[2].data, 4'b1111, 8);

        // Timeout with err_clr held (set wins), recovery frame, then clear
        wait_idle();
        timeout_frame(vecs[0].data, 1'b1);
        load_mask(vecs[0].mask);
        send_beats(vecs[0].data, 0, 8);
        launch_and_drain(vecs[0].exp_din, 4'b1111, 8);
        check_bit("err_sticky", err_tmo, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_bit("err_cleared", err_tmo, 1'b0);

        // Async reset mid-drain with err_tmo set, then a clean frame
        timeout_frame(vecs[3].data, 1'b0);
        load_mask(vecs[1].mask);
        send_beats(vecs[1].data, 0, 8);
        launch_and_drain(vecs[1].exp_din, 4'b1111, 4);
        wait_idle();
        send_beats(vecs[3].data, 0, 8);
        launch_and_drain(vecs[3].exp_din, 4'b1111, 8);
        check_bit("final_err_tmo", err_tmo, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
